// File: rtl/cpu_controller.sv
// Sequencing control unit: steps the 8-phase instruction cycle and decodes the
// opcode into per-phase control strobes, with fetch stalls and a sticky halt.
module cpu_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       halt,
  output logic       inc_pc,
  output logic       ld_ac,
  output logic       ld_pc,
  output logic       wr,
  output logic       data_e,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    StInstAddr  = 3'd0,
    StInstFetch = 3'd1,
    StInstLoad  = 3'd2,
    StIdle      = 3'd3,
    StOpAddr    = 3'd4,
    StOpFetch   = 3'd5,
    StAluOp     = 3'd6,
    StStore     = 3'd7
  } phase_e;

  localparam logic [2:0] OpHlt = 3'd0;
  localparam logic [2:0] OpSkz = 3'd1;
  localparam logic [2:0] OpAdd = 3'd2;
  localparam logic [2:0] OpAnd = 3'd3;
  localparam logic [2:0] OpXor = 3'd4;
  localparam logic [2:0] OpLda = 3'd5;
  localparam logic [2:0] OpSto = 3'd6;
  localparam logic [2:0] OpJmp = 3'd7;

  phase_e phase_q, phase_d, phase_inc;
  logic   halted_q, halted_d;
  logic   alu_op;

  assign phase_inc = phase_e'(phase_q + 3'd1);
  assign alu_op    = (opcode == OpAdd) || (opcode == OpAnd) ||
                     (opcode == OpXor) || (opcode == OpLda);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q  <= StInstAddr;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    phase_d  = phase_q;
    halted_d = halted_q;
    if (!halted_q) begin
      unique case (phase_q)
        StInstFetch, StOpFetch: if (mem_ready) phase_d = phase_inc;
        // HLT freezes the phase at OP_ADDR; only rst leaves it.
        StOpAddr: begin
          if (opcode == OpHlt) halted_d = 1'b1;
          else                 phase_d  = phase_inc;
        end
        default: phase_d = phase_inc;
      endcase
    end
  end

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    halt   = 1'b0;
    inc_pc = 1'b0;
    ld_ac  = 1'b0;
    ld_pc  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    if (halted_q) begin
      halt = 1'b1;
    end else begin
      unique case (phase_q)
        StInstAddr: sel = 1'b1;
        StInstFetch: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        StInstLoad, StIdle: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        StOpAddr: begin
          inc_pc = 1'b1;
          halt   = (opcode == OpHlt);
        end
        StOpFetch: rd = alu_op;
        StAluOp: begin
          rd     = alu_op;
          inc_pc = (opcode == OpSkz) && zero;
          ld_pc  = (opcode == OpJmp);
          data_e = (opcode == OpSto);
        end
        StStore: begin
          rd     = alu_op;
          ld_ac  = alu_op;
          ld_pc  = (opcode == OpJmp);
          wr     = (opcode == OpSto);
          data_e = (opcode == OpSto);
        end
        default: ;
      endcase
    end
  end

  assign phase = phase_q;

endmodule
